mem_arbiter: RTL

Single-port memory arbiter and access sequencer between the instruction-fetch path and the load/store path of the RISC-V CPU. It grants a shared word-wide synchronous memory to one requester at a time, alternating on contention. It holds the access for a fixed number of wait cycles and applies byte/half/word lane selection and load sign/zero extension from the decoder's memory-type and memory-sign signals. It asserts a stall to the pipeline while any request is outstanding.

---
 rtl/mem_arbiter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, with lane
// select and load extension. Define MEM_ARB_MISALIGN_TRAP_EN to flag misaligned data accesses.
module mem_arbiter #(
   parameter int AW      = 32,
   parameter int MEM_LAT = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req_i,
   input  logic [AW-1:0] if_addr_i,
   output logic          if_ready_o,
   output logic [31:0]   if_rdata_o,
   input  logic          d_req_i,
   input  logic          d_we_i,
   input  logic [AW-1:0] d_addr_i,
   input  logic [31:0]   d_wdata_i,
   input  logic [1:0]    d_type_i,
   input  logic          d_sign_i,
   output logic          d_ready_o,
   output logic [31:0]   d_rdata_o,
   output logic          d_misalign_o,
   output logic          mem_en_o,
   output logic          mem_we_o,
   output logic [3:0]    mem_be_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [31:0]   mem_wdata_o,
   input  logic [31:0]   mem_rdata_i,
   output logic          stall_o
);
   typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;
   localparam int CW = $clog2(MEM_LAT + 1);

   state_t          state_reg, state_next;
   logic [CW-1:0]   count_reg, count_next;
   logic [AW-1:0]   addr_reg, addr_next;
   logic            we_reg, we_next;
   logic [3:0]      be_reg, be_next;
   logic [31:0]     wdata_reg, wdata_next;
   logic [1:0]      type_reg, type_next;
   logic            sign_reg, sign_next;
   logic            gnt_d_reg, gnt_d_next;    // 1 = data port owns the access
   logic            last_d_reg, last_d_next;  // 1 = data port was served last
   logic            if_ready_reg, if_ready_next;
   logic            d_ready_reg, d_ready_next;
   logic [31:0]     if_rdata_reg, if_rdata_next;
   logic [31:0]     d_rdata_reg, d_rdata_next;
   logic            grant_d;
   logic [3:0]      lane_be;
   logic [31:0]     lane_wdata;
`ifdef MEM_ARB_MISALIGN_TRAP_EN
   logic            misalign_reg, misalign_next;
   logic            misaligned;
`endif

   function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] t,
                                          input logic s, input logic [1:0] o);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{o, 3'b000} +: 8];
      h = o[1] ? w[31:16] : w[15:0];
      case (t)
         2'b01:   extend = {{24{s & b[7]}}, b};
         2'b10:   extend = {{16{s & h[15]}}, h};
         default: extend = w;
      endcase
   endfunction

   always_comb begin
      state_next    = state_reg;
      count_next    = count_reg;
      addr_next     = addr_reg;
      we_next       = we_reg;
      be_next       = be_reg;
      wdata_next    = wdata_reg;
      type_next     = type_reg;
      sign_next     = sign_reg;
      gnt_d_next    = gnt_d_reg;
      last_d_next   = last_d_reg;
      if_ready_next = 1'b0;
      d_ready_next  = 1'b0;
      if_rdata_next = if_rdata_reg;
      d_rdata_next  = d_rdata_reg;
      grant_d       = d_req_i & (~if_req_i | ~last_d_reg);
      case (d_type_i)
         2'b01: begin
            lane_be    = 4'b0001 << d_addr_i[1:0];
            lane_wdata = {4{d_wdata_i[7:0]}};
         end
         2'b10: begin
            lane_be    = d_addr_i[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{d_wdata_i[15:0]}};
         end
         default: begin
            lane_be    = 4'b1111;
            lane_wdata = d_wdata_i;
         end
      endcase
`ifdef MEM_ARB_MISALIGN_TRAP_EN
      misalign_next = misalign_reg;
      misaligned    = ((d_type_i == 2'b10) & d_addr_i[0]) |
                      ((d_type_i[0] == d_type_i[1]) & (d_addr_i[1:0] != 2'b00));
`endif

      case (state_reg)
         IDLE: begin
            if (if_req_i | d_req_i) begin
               gnt_d_next = grant_d;
               state_next = ACC;
               count_next = CW'(MEM_LAT - 1);
               if (grant_d) begin
                  addr_next  = d_addr_i;
                  we_next    = d_we_i;
                  be_next    = lane_be;
                  wdata_next = lane_wdata;
                  type_next  = d_type_i;
                  sign_next  = d_sign_i;
               end else begin
                  addr_next  = if_addr_i;
                  we_next    = 1'b0;
                  be_next    = 4'b1111;
                  wdata_next = 32'h0;
                  type_next  = 2'b00;
                  sign_next  = 1'b0;
               end
`ifdef MEM_ARB_MISALIGN_TRAP_EN
               // Misaligned data access: answer immediately, never touch memory.
               if (grant_d && misaligned) begin
                  state_next    = RESP;
                  count_next    = '0;
                  d_ready_next  = 1'b1;
                  d_rdata_next  = 32'h0;
                  misalign_next = 1'b1;
               end
`endif
            end
         end
         ACC: begin
            count_next = count_reg - 1'b1;
            if (count_reg == '0) begin
               count_next = '0;
               state_next = RESP;
               if (gnt_d_reg) begin
                  d_ready_next = 1'b1;
                  d_rdata_next = we_reg ? 32'h0
                                        : extend(mem_rdata_i, type_reg, sign_reg, addr_reg[1:0]);
               end else begin
                  if_ready_next = 1'b1;
                  if_rdata_next = mem_rdata_i;
               end
            end
         end
         RESP: begin
            last_d_next = gnt_d_reg;
            state_next  = IDLE;
`ifdef MEM_ARB_MISALIGN_TRAP_EN
            misalign_next = 1'b0;
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         count_reg    <= '0;
         addr_reg     <= '0;
         we_reg       <= 1'b0;
         be_reg       <= 4'b0000;
         wdata_reg    <= 32'h0;
         type_reg     <= 2'b00;
         sign_reg     <= 1'b0;
         gnt_d_reg    <= 1'b0;
         last_d_reg   <= 1'b0;
         if_ready_reg <= 1'b0;
         d_ready_reg  <= 1'b0;
         if_rdata_reg <= 32'h0;
         d_rdata_reg  <= 32'h0;
`ifdef MEM_ARB_MISALIGN_TRAP_EN
         misalign_reg <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         count_reg    <= count_next;
         addr_reg     <= addr_next;
         we_reg       <= we_next;
         be_reg       <= be_next;
         wdata_reg    <= wdata_next;
         type_reg     <= type_next;
         sign_reg     <= sign_next;
         gnt_d_reg    <= gnt_d_next;
         last_d_reg   <= last_d_next;
         if_ready_reg <= if_ready_next;
         d_ready_reg  <= d_ready_next;
         if_rdata_reg <= if_rdata_next;
         d_rdata_reg  <= d_rdata_next;
`ifdef MEM_ARB_MISALIGN_TRAP_EN
         misalign_reg <= misalign_next;
`endif
      end
   end

   // Memory-side signals are gated so they read zero outside an access.
   assign mem_en_o    = (state_reg == ACC);
   assign mem_we_o    = mem_en_o & we_reg & (count_reg == CW'(MEM_LAT - 1));
   assign mem_be_o    = mem_en_o ? be_reg : 4'b0000;
   assign mem_addr_o  = mem_en_o ? {addr_reg[AW-1:2], 2'b00} : '0;
   assign mem_wdata_o = mem_en_o ? wdata_reg : 32'h0;
   assign if_ready_o  = if_ready_reg;
   assign if_rdata_o  = if_rdata_reg;
   assign d_ready_o   = d_ready_reg;
   assign d_rdata_o   = d_rdata_reg;
`ifdef MEM_ARB_MISALIGN_TRAP_EN
   assign d_misalign_o = misalign_reg;
`else
   assign d_misalign_o = 1'b0;
`endif
   assign stall_o = (if_req_i & ~if_ready_o) | (d_req_i & ~d_ready_o);
endmodule
